uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter FIFO_DEPTH_LOG2, default 4; entry count 2**FIFO_DEPTH_LOG2, legal range 2..8.
REQ-002 SHALL have parameter AFULL_LEVEL, default 12; almost_full threshold, legal range 1..2**FIFO_DEPTH_LOG2.
REQ-003 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port in_ready  out  1  FIFO can accept (drives the receiver phy's out_ready).
REQ-006 SHALL have port in_valid  in  1  byte offered by the receiver phy.
REQ-007 SHALL have port in_data  in  8  received byte.
REQ-008 SHALL have port in_error  in  2  phy status, [0] overrun, [1] framing (level, not strobe).
REQ-009 SHALL have port out_ready  in  1  consumer accepts head entry.
REQ-010 SHALL have port out_valid  out  1  head entry available.
REQ-011 SHALL have port out_data  out  8  head entry byte.
REQ-012 SHALL have port out_overrun  out  1  head entry was preceded by byte loss in the phy.
REQ-013 SHALL have port level  out  FIFO_DEPTH_LOG2+1  current occupancy.
REQ-014 SHALL have port almost_full  out  1  level >= AFULL_LEVEL.
REQ-015 SHALL have port frame_error  out  1  sticky framing-error flag.
REQ-016 SHALL have port err_clear  in  1  one-cycle pulse clearing sticky status.

Function
REQ-017 SHALL store 9-bit entries {in_error[0], in_data} in a circular buffer with write and read pointers of FIFO_DEPTH_LOG2 bits that wrap modulo depth.
REQ-018 SHALL assert in_ready exactly when level < depth (combinational from registered level).
REQ-019 SHALL push when in_valid && in_ready; pushed entry visible at head no earlier than the cycle after the push edge.
REQ-020 SHALL assert out_valid exactly when level != 0; out_data/out_overrun SHALL be head entry, stable while out_valid && !out_ready.
REQ-021 SHALL pop when out_valid && out_ready; read pointer advances on that edge.
REQ-022 SHALL on simultaneous push and pop leave level unchanged and advance both pointers.
REQ-023 SHALL never push when full and never pop when empty; push into empty FIFO with out_ready high SHALL not pop that entry in the same cycle.
REQ-024 SHALL update level +1 on push-only, -1 on pop-only, unchanged otherwise; level range 0..depth inclusive.
REQ-025 SHALL assert almost_full combinationally from level >= AFULL_LEVEL.
REQ-026 SHALL set frame_error on any cycle with in_error[1]==1, independent of in_valid.
REQ-027 SHALL clear frame_error on err_clear; if set condition and err_clear coincide, set SHALL win.

Reset
REQ-028 SHALL on reset (synchronous, any cycle, including mid-transfer) zero both pointers, level, frame_error and counters; outputs after reset edge: in_ready=1, out_valid=0, level=0, almost_full=0, frame_error=0.
REQ-029 SHALL treat buffer contents as don't-care after reset; out_data/out_overrun undefined while out_valid=0.

Configuration
REQ-030 SHALL, with macro UART_RX_FIFO_ERRCNT_EN defined, add outputs frame_count[7:0] and overrun_count[7:0].
REQ-031 SHALL with macro defined increment frame_count on each rising edge of in_error[1] (0->1 between consecutive cycles) and overrun_count on each push with in_error[0]==1; both saturate at 8'hFF.
REQ-032 SHALL with macro defined clear both counters on err_clear; a coincident increment SHALL result in value 1.
REQ-033 SHALL without macro omit both ports and all counter logic; remaining behaviour identical.

Verification
REQ-034 Push 0x55 with out_ready=0 -> next cycle out_valid=1, out_data=0x55, level=1; assert out_ready one cycle -> out_valid=0, level=0.
REQ-035 Default params, out_ready=0, push 16 bytes 0x00..0x0F -> almost_full=1 once level=12, in_ready=0 at level=16; drain -> bytes 0x00..0x0F in order, pointers wrapped, in_ready=1.
REQ-036 Level 5, in_valid=1 and out_ready=1 together for 10 cycles -> level stays 5, output order preserved.
REQ-037 Hold in_error[1]=1 three cycles, then err_clear -> frame_error=1 until cleared; with UART_RX_FIFO_ERRCNT_EN frame_count=1, then 0 after clear.
REQ-038 Push 0xA5 with in_error[0]=1 -> head out_overrun=1; with macro overrun_count=1; 300 such pushes with draining -> count saturates at 0xFF.
REQ-039 Reset asserted at level 7 during push/pop -> after edge level=0, out_valid=0, in_ready=1, frame_error=0.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side byte FIFO sitting behind a UART phy.
// Stores {overrun, byte} entries, reports occupancy/almost_full and keeps a
// sticky framing-error flag. Define UART_RX_FIFO_ERRCNT_EN to add saturating
// frame_count / overrun_count outputs.
module uart_rx_fifo #(
  parameter int FIFO_DEPTH_LOG2 = 4,
  parameter int AFULL_LEVEL     = 12
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     in_ready,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  input  logic [1:0]               in_error,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [7:0]               out_data,
  output logic                     out_overrun,
  output logic [FIFO_DEPTH_LOG2:0] level,
  output logic                     almost_full,
  output logic                     frame_error,
  input  logic                     err_clear
`ifdef UART_RX_FIFO_ERRCNT_EN
  ,
  output logic [7:0]               frame_count,
  output logic [7:0]               overrun_count
`endif
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int LW    = FIFO_DEPTH_LOG2 + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0] AFULL_L = LW'(AFULL_LEVEL);

  logic [8:0]                 mem_q [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]              level_q, level_d;
  logic                       ferr_q, ferr_d;
  logic                       push, pop;

  // Handshakes depend only on registered level, so a byte pushed into an
  // empty FIFO can never be popped in the same cycle.
  assign in_ready    = (level_q < DEPTH_L);
  assign out_valid   = (level_q != '0);
  assign push        = in_valid && in_ready;
  assign pop         = out_valid && out_ready;
  assign out_data    = mem_q[rd_ptr_q][7:0];
  assign out_overrun = mem_q[rd_ptr_q][8];
  assign level       = level_q;
  assign almost_full = (level_q >= AFULL_L);
  assign frame_error = ferr_q;

  // Next-state for pointers, occupancy and the sticky framing flag.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d  = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    // set has priority over clear
    ferr_d = ferr_q;
    if (err_clear)   ferr_d = 1'b0;
    if (in_error[1]) ferr_d = 1'b1;
  end

  // Storage array; contents are don't-care after reset, so it has none.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_error[0], in_data};
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ferr_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ferr_q   <= ferr_d;
    end
  end

`ifdef UART_RX_FIFO_ERRCNT_EN
  logic       ferr_prev_q;
  logic [7:0] fcnt_q, fcnt_d;
  logic [7:0] ocnt_q, ocnt_d;
  logic       f_inc, o_inc;

  assign f_inc         = in_error[1] && !ferr_prev_q;
  assign o_inc         = push && in_error[0];
  assign frame_count   = fcnt_q;
  assign overrun_count = ocnt_q;

  // Saturating counters; a clear coinciding with an increment leaves 1.
  always_comb begin
    fcnt_d = fcnt_q;
    ocnt_d = ocnt_q;
    if (err_clear)                    fcnt_d = {7'd0, f_inc};
    else if (f_inc && fcnt_q != 8'hFF) fcnt_d = fcnt_q + 8'd1;
    if (err_clear)                    ocnt_d = {7'd0, o_inc};
    else if (o_inc && ocnt_q != 8'hFF) ocnt_d = ocnt_q + 8'd1;
  end

  // Counter registers plus the previous framing level for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      ferr_prev_q <= 1'b0;
      fcnt_q      <= '0;
      ocnt_q      <= '0;
    end else begin
      ferr_prev_q <= in_error[1];
      fcnt_q      <= fcnt_d;
      ocnt_q      <= ocnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo (default parameters). Inputs change and
// outputs are sampled on the falling edge, midway between active edges.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       reset, in_ready, in_valid, out_ready, out_valid, out_overrun;
  logic       almost_full, frame_error, err_clear;
  logic [7:0] in_data, out_data;
  logic [1:0] in_error;
  logic [4:0] level;
`ifdef UART_RX_FIFO_ERRCNT_EN
  logic [7:0] frame_count, overrun_count;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  uart_rx_fifo #(.FIFO_DEPTH_LOG2(4), .AFULL_LEVEL(12)) dut (
    .clk(clk), .reset(reset), .in_ready(in_ready), .in_valid(in_valid),
    .in_data(in_data), .in_error(in_error), .out_ready(out_ready),
    .out_valid(out_valid), .out_data(out_data), .out_overrun(out_overrun),
    .level(level), .almost_full(almost_full), .frame_error(frame_error),
    .err_clear(err_clear)
`ifdef UART_RX_FIFO_ERRCNT_EN
    , .frame_count(frame_count), .overrun_count(overrun_count)
`endif
  );

  task automatic test_reset;
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_error = '0;
    out_ready = 1'b0; err_clear = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", level); end
    checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL reset_afull got %b exp 0", almost_full); end
    checks++; if (frame_error !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b exp 0", frame_error); end
`ifdef UART_RX_FIFO_ERRCNT_EN
    checks++; if (frame_count !== 8'd0 || overrun_count !== 8'd0) begin errors++; $display("FAIL reset_counts got %0d/%0d exp 0/0", frame_count, overrun_count); end
`endif
  endtask

  task automatic test_single;
    in_valid = 1'b1; in_data = 8'h55;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", out_valid); end
    checks++; if (out_data !== 8'h55) begin errors++; $display("FAIL single_data got %h exp 55", out_data); end
    checks++; if (out_overrun !== 1'b0) begin errors++; $display("FAIL single_ovr got %b exp 0", out_overrun); end
    checks++; if (level !== 5'd1) begin errors++; $display("FAIL single_level got %0d exp 1", level); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || level !== 5'd0) begin errors++; $display("FAIL single_pop got v=%b l=%0d exp v=0 l=0", out_valid, level); end
  endtask

  task automatic test_fill_drain;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_data = 8'(i);
      @(negedge clk);
      checks++; if (level !== 5'(i + 1)) begin errors++; $display("FAIL fill_level[%0d] got %0d exp %0d", i, level, i + 1); end
      checks++; if (almost_full !== (i + 1 >= 12)) begin errors++; $display("FAIL fill_afull[%0d] got %b exp %b", i, almost_full, (i + 1 >= 12)); end
      checks++; if (in_ready !== (i + 1 < 16)) begin errors++; $display("FAIL fill_in_ready[%0d] got %b exp %b", i, in_ready, (i + 1 < 16)); end
    end
    // push attempt while full must be ignored
    in_data = 8'hEE;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (level !== 5'd16) begin errors++; $display("FAIL full_push_level got %0d exp 16", level); end
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      checks++; if (out_valid !== 1'b1 || out_data !== 8'(i)) begin errors++; $display("FAIL drain[%0d] got v=%b d=%h exp v=1 d=%h", i, out_valid, out_data, 8'(i)); end
      @(negedge clk);
    end
    // pop attempt while empty must be ignored
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if (level !== 5'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL drained got l=%0d v=%b r=%b exp 0/0/1", level, out_valid, in_ready); end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 8'h20 + 8'(i);
      @(negedge clk);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in_data = 8'h25 + 8'(k);
      checks++; if (out_data !== 8'h20 + 8'(k)) begin errors++; $display("FAIL b2b_data[%0d] got %h exp %h", k, out_data, 8'h20 + 8'(k)); end
      @(negedge clk);
      checks++; if (level !== 5'd5) begin errors++; $display("FAIL b2b_level[%0d] got %0d exp 5", k, level); end
    end
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      checks++; if (out_data !== 8'h2A + 8'(k)) begin errors++; $display("FAIL b2b_tail[%0d] got %h exp %h", k, out_data, 8'h2A + 8'(k)); end
      @(negedge clk);
    end
    out_ready = 1'b0;
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL b2b_empty got %0d exp 0", level); end
  endtask

  task automatic test_frame_error;
    in_error = 2'b10;
    repeat (3) @(negedge clk);
    in_error = 2'b00;
    checks++; if (frame_error !== 1'b1) begin errors++; $display("FAIL ferr_set got %b exp 1", frame_error); end
    @(negedge clk);
    checks++; if (frame_error !== 1'b1) begin errors++; $display("FAIL ferr_sticky got %b exp 1", frame_error); end
`ifdef UART_RX_FIFO_ERRCNT_EN
    checks++; if (frame_count !== 8'd1) begin errors++; $display("FAIL fcnt_one got %0d exp 1", frame_count); end
`endif
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    checks++; if (frame_error !== 1'b0) begin errors++; $display("FAIL ferr_clear got %b exp 0", frame_error); end
`ifdef UART_RX_FIFO_ERRCNT_EN
    checks++; if (frame_count !== 8'd0) begin errors++; $display("FAIL fcnt_clear got %0d exp 0", frame_count); end
`endif
    // set and clear together: set wins, coincident increment leaves 1
    in_error = 2'b10; err_clear = 1'b1;
    @(negedge clk);
    in_error = 2'b00; err_clear = 1'b0;
    checks++; if (frame_error !== 1'b1) begin errors++; $display("FAIL ferr_set_wins got %b exp 1", frame_error); end
`ifdef UART_RX_FIFO_ERRCNT_EN
    checks++; if (frame_count !== 8'd1) begin errors++; $display("FAIL fcnt_coincide got %0d exp 1", frame_count); end
`endif
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    checks++; if (frame_error !== 1'b0) begin errors++; $display("FAIL ferr_clear2 got %b exp 0", frame_error); end
  endtask

  task automatic test_overrun;
    in_valid = 1'b1; in_data = 8'hA5; in_error = 2'b01;
    @(negedge clk);
    in_valid = 1'b0; in_error = 2'b00;
    checks++; if (out_overrun !== 1'b1 || out_data !== 8'hA5) begin errors++; $display("FAIL ovr_head got o=%b d=%h exp o=1 d=a5", out_overrun, out_data); end
    checks++; if (frame_error !== 1'b0) begin errors++; $display("FAIL ovr_no_ferr got %b exp 0", frame_error); end
`ifdef UART_RX_FIFO_ERRCNT_EN
    checks++; if (overrun_count !== 8'd1) begin errors++; $display("FAIL ocnt_one got %0d exp 1", overrun_count); end
    in_valid = 1'b1; in_error = 2'b01; out_ready = 1'b1;
    repeat (300) @(negedge clk);
    in_valid = 1'b0; in_error = 2'b00;
    checks++; if (overrun_count !== 8'hFF) begin errors++; $display("FAIL ocnt_sat got %0d exp 255", overrun_count); end
    err_clear = 1'b1;
`endif
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0; err_clear = 1'b0;
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL ovr_drain got %0d exp 0", level); end
`ifdef UART_RX_FIFO_ERRCNT_EN
    checks++; if (overrun_count !== 8'd0) begin errors++; $display("FAIL ocnt_clear got %0d exp 0", overrun_count); end
`endif
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1; in_data = 8'h70 + 8'(i);
      @(negedge clk);
    end
    in_valid = 1'b0; in_error = 2'b10;
    @(negedge clk);
    in_error = 2'b00;
    checks++; if (level !== 5'd7 || frame_error !== 1'b1) begin errors++; $display("FAIL pre_reset got l=%0d f=%b exp 7/1", level, frame_error); end
    in_valid = 1'b1; out_ready = 1'b1; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (level !== 5'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset got l=%0d v=%b exp 0/0", level, out_valid); end
    checks++; if (in_ready !== 1'b1 || frame_error !== 1'b0 || almost_full !== 1'b0) begin errors++; $display("FAIL mid_reset_flags got r=%b f=%b a=%b exp 1/0/0", in_ready, frame_error, almost_full); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_drain();
    test_back_to_back();
    test_frame_error();
    test_overrun();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
